modaddsub_vec: RTL
==================

# modaddsub_vec

Pipelined, multi-lane modular add/subtract unit with valid/ready flow control, the next generation of the single-lane `modsub` block. Each accepted beat carries NLANE operand pairs, one shared operation (add or subtract), one sparse modulus and a sideband tag. Results emerge in order after a fixed, parameter-selected latency. It sits between the NTT/modmul datapaths and their operand buffers, where a stall-capable stream interface is required.

## Interface
- NLANE, 4: number of parallel lanes per beat
- LOGQ, 64: operand/result/modulus width
- LOGQH, 47: significant high bits of the modulus
- TAGW, 8: sideband tag width
- FF_IN, 1: input register stage present (0/1)
- FF_OP, 1: register after raw add/sub (0/1)
- FF_OUT, 1: output register stage present (0/1)
- localparam LAT = FF_IN + FF_OP + FF_OUT

- clk  in  1  clock
- rst  in  1  reset; synchronous, active-high
- in_valid  in  1  input beat valid
- in_ready  out  1  input beat accepted when in_valid && in_ready
- in_op  in  1  0 = add, 1 = sub
- in_qh  in  LOGQH  modulus high bits; q = {in_qh, (LOGQ-LOGQH-1)'b0, 1'b1}
- in_a  in  NLANE*LOGQ  lane operands A, lane 0 in LSBs
- in_b  in  NLANE*LOGQ  lane operands B
- in_tag  in  TAGW  sideband, passed through unchanged
- out_valid  out  1  result beat valid
- out_ready  in  1  downstream accepts
- out_c  out  NLANE*LOGQ  lane results
- out_tag  out  TAGW  tag of the beat

## Operation
- Operand contract: 0 <= A, B < q per lane. Results are then in [0, q). Out-of-range operands give undefined but deterministic output; no checking.
- Add: R = A + B at LOGQ+1 bits, Rq = R - q at LOGQ+2 bits signed; C = Rq if Rq >= 0, else R[LOGQ-1:0].
- Sub: R = A - B at LOGQ+1 bits; Rq = R + q; C = R[LOGQ-1:0] if R[LOGQ] == 0, else Rq[LOGQ-1:0].
- Both candidates are computed in the stage before FF_OP. Selection happens after FF_OP.
- op, qh and tag travel with the beat through every stage. Each beat may use a different op and q.
- Flow control uses a single global enable: en = !out_valid || out_ready. All stage registers, including stage valid bits, advance only when en is high.
- in_ready = en && !rst.
- Bubbles (stage valid = 0) are carried and are not collapsed. Throughput is 1 beat/cycle when out_ready is held high.
- With LAT = 0 the block is combinational: out_valid = in_valid, in_ready = out_ready.

## Timing
- Reset: all stage valids are cleared, so out_valid = 0. out_c and out_tag = 0. in_ready = 0 while rst is high and returns to 1 on the first cycle after.
- Reset mid-stream: all in-flight beats are discarded and none appear at the output. No partial beat appears after reset.
- Latency: a beat accepted in cycle t appears with out_valid in cycle t+LAT, provided en was high in every intervening cycle. Each cycle with en low adds exactly one cycle.
- Stall hold: while out_valid && !out_ready, out_c, out_tag and out_valid remain stable. No beat is dropped or duplicated.
- Simultaneous accept and emit in the same cycle is allowed and is the normal steady state.
- Ordering: strictly FIFO. out_tag sequence equals in_tag sequence.

## Structure
- Package `modop_pkg`:
  - op encoding constants OP_ADD = 1'b0, OP_SUB = 1'b1
  - function `q_expand(qh)` returning the full LOGQ-bit modulus
  - localparam LAT formula
- Sub-module `modaddsub_lane`: one lane's datapath (candidate generation, select) with its FF_OP and FF_OUT registers. It takes the shared en, op and q. The top level instantiates NLANE lanes via generate and owns the valid/tag/op/q pipeline and the handshake.

## Test plan
Common settings: LOGQ = 64, LOGQH = 47, q = 0x1111100000000001, all FF = 1 (LAT = 3) unless noted.
- Sub wrap: A = 0x010000000000000A, B = 0x1000000000000005, op = sub -> C = 0x0211100000000006, exactly 3 cycles after accept.
- Add wrap: A = 0x1111100000000000, B = 2 -> C = 1. Add no wrap: A = 5, B = 7 -> C = 12. Sub equal: A = B = 0x55 -> C = 0.
- Lanes/op mix: NLANE = 4, back-to-back beats alternating add/sub with distinct per-lane values -> each lane matches the reference model. No cross-lane leakage.
- Backpressure: 16 beats with tags 0..15, out_ready pseudo-random at 50% -> all 16 results correct, in order, stable while stalled, no loss or duplication.
- Reset mid-stream: assert rst for 1 cycle with 3 beats in flight -> out_valid = 0 the next cycle. Those beats never appear. in_ready = 0 during rst. A new beat after reset emerges with LAT latency.
- Parameter sweep: all 8 FF_IN/FF_OP/FF_OUT combinations (LAT 0..3) -> observed latency = LAT, results identical. LAT = 0 passes in_ready = out_ready.

Source files
------------

// File: rtl/modaddsub_vec_pkg.sv
// Shared definitions for the multi-lane modular add/subtract unit:
// op encoding, default widths, latency formula and modulus expansion.
package modop_pkg;

  localparam int NLANE_DEF = 4;
  localparam int LOGQ_DEF  = 64;
  localparam int LOGQH_DEF = 47;
  localparam int TAGW_DEF  = 8;

  localparam logic OP_ADD = 1'b0;
  localparam logic OP_SUB = 1'b1;

  // Pipeline latency is simply the number of register stages present.
  function automatic int lat_of(input int ff_in, input int ff_op, input int ff_out);
    return ff_in + ff_op + ff_out;
  endfunction

  // Sparse modulus: high bits, a run of zeros, and a forced odd LSB.
  function automatic logic [LOGQ_DEF-1:0] q_expand(input logic [LOGQH_DEF-1:0] qh);
    return {qh, {(LOGQ_DEF-LOGQH_DEF-1){1'b0}}, 1'b1};
  endfunction

endpackage

// File: rtl/modaddsub_vec_if.sv
// Stream interface for modaddsub_vec: input beat (valid/ready) and
// result beat (valid/ready) grouped in one bundle.
interface modaddsub_vec_if
  import modop_pkg::*;
#(
  parameter int NLANE = NLANE_DEF,
  parameter int LOGQ  = LOGQ_DEF,
  parameter int LOGQH = LOGQH_DEF,
  parameter int TAGW  = TAGW_DEF
);

  logic                  in_valid;
  logic                  in_ready;
  logic                  in_op;
  logic [LOGQH-1:0]      in_qh;
  logic [NLANE*LOGQ-1:0] in_a;
  logic [NLANE*LOGQ-1:0] in_b;
  logic [TAGW-1:0]       in_tag;
  logic                  out_valid;
  logic                  out_ready;
  logic [NLANE*LOGQ-1:0] out_c;
  logic [TAGW-1:0]       out_tag;

  // Producer/consumer side driving the unit.
  modport master (
    output in_valid, in_op, in_qh, in_a, in_b, in_tag, out_ready,
    input  in_ready, out_valid, out_c, out_tag
  );

  // The arithmetic unit itself.
  modport slave (
    input  in_valid, in_op, in_qh, in_a, in_b, in_tag, out_ready,
    output in_ready, out_valid, out_c, out_tag
  );

endinterface

// File: rtl/modaddsub_lane.sv
// One lane of the modular add/subtract datapath: builds both candidates
// (raw result and modulus-corrected result), optionally registers them,
// selects by sign after that register, and optionally registers the result.
module modaddsub_lane
  import modop_pkg::*;
#(
  parameter int LOGQ   = LOGQ_DEF,
  parameter int FF_OP  = 1,
  parameter int FF_OUT = 1
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            en,
  input  logic            op_cand,
  input  logic            op_sel,
  input  logic [LOGQ-1:0] q,
  input  logic [LOGQ-1:0] a,
  input  logic [LOGQ-1:0] b,
  output logic [LOGQ-1:0] c
);

  logic [LOGQ:0]   r;
  logic [LOGQ+1:0] rq;
  logic [LOGQ:0]   r2;
  logic [LOGQ+1:0] rq2;
  logic [LOGQ-1:0] sel;
  logic            unused_rq;

  // Candidate generation: raw sum/difference and its q-corrected twin.
  always_comb begin
    r  = '0;
    rq = '0;
    if (op_cand == OP_SUB) begin
      r  = {1'b0, a} - {1'b0, b};
      rq = {1'b0, r} + {2'b00, q};
    end else begin
      r  = {1'b0, a} + {1'b0, b};
      rq = {1'b0, r} - {2'b00, q};
    end
  end

  generate
    if (FF_OP != 0) begin : g_op_reg
      // Hold both candidates so the select sits in the following stage.
      always_ff @(posedge clk) begin
        if (rst) begin
          r2  <= '0;
          rq2 <= '0;
        end else if (en) begin
          r2  <= r;
          rq2 <= rq;
        end
      end
    end else begin : g_op_wire
      assign r2  = r;
      assign rq2 = rq;
    end
  endgenerate

  // Bit LOGQ of the corrected candidate never decides anything.
  assign unused_rq = rq2[LOGQ];

  // Select: sub keeps a non-negative difference, add keeps a non-negative R-q.
  always_comb begin
    sel = '0;
    if (op_sel == OP_SUB) begin
      if (r2[LOGQ]) begin
        sel = rq2[LOGQ-1:0];
      end else begin
        sel = r2[LOGQ-1:0];
      end
    end else begin
      if (rq2[LOGQ+1]) begin
        sel = r2[LOGQ-1:0];
      end else begin
        sel = rq2[LOGQ-1:0];
      end
    end
  end

  generate
    if (FF_OUT != 0) begin : g_out_reg
      // Registered lane result.
      always_ff @(posedge clk) begin
        if (rst) begin
          c <= '0;
        end else if (en) begin
          c <= sel;
        end
      end
    end else begin : g_out_wire
      assign c = sel;
    end
  endgenerate

endmodule

// File: rtl/modaddsub_vec.sv
// Multi-lane pipelined modular add/subtract with valid/ready flow control.
// The top owns the valid/op/modulus/tag pipeline and the global stall
// enable; each lane owns its arithmetic and the matching data registers.
module modaddsub_vec
  import modop_pkg::*;
#(
  parameter int NLANE  = NLANE_DEF,
  parameter int LOGQ   = LOGQ_DEF,
  parameter int LOGQH  = LOGQH_DEF,
  parameter int TAGW   = TAGW_DEF,
  parameter int FF_IN  = 1,
  parameter int FF_OP  = 1,
  parameter int FF_OUT = 1
) (
  input logic            clk,
  input logic            rst,
  modaddsub_vec_if.slave bus
);

  localparam int LAT = lat_of(FF_IN, FF_OP, FF_OUT);
  localparam int W   = NLANE * LOGQ;

  logic             en;
  logic             s1_valid, s2_valid, s3_valid;
  logic             s1_op, s2_op;
  logic [LOGQH-1:0] s1_qh;
  logic [TAGW-1:0]  s1_tag, s2_tag, s3_tag;
  logic [W-1:0]     s1_a, s1_b;
  logic [LOGQ-1:0]  q1;
  logic [W-1:0]     lane_c;

  // The whole pipeline moves as one: it advances unless the output is stuck.
  assign en = !s3_valid || bus.out_ready;

  generate
    if (LAT == 0) begin : g_ready_comb
      assign bus.in_ready = bus.out_ready;
    end else begin : g_ready_pipe
      assign bus.in_ready = en && !rst;
    end
  endgenerate

  generate
    if (FF_IN != 0) begin : g_in_reg
      // Input stage: capture the beat (or a bubble) whenever the pipe moves.
      always_ff @(posedge clk) begin
        if (rst) begin
          s1_valid <= 1'b0;
          s1_op    <= 1'b0;
          s1_qh    <= '0;
          s1_tag   <= '0;
          s1_a     <= '0;
          s1_b     <= '0;
        end else if (en) begin
          s1_valid <= bus.in_valid;
          s1_op    <= bus.in_op;
          s1_qh    <= bus.in_qh;
          s1_tag   <= bus.in_tag;
          s1_a     <= bus.in_a;
          s1_b     <= bus.in_b;
        end
      end
    end else begin : g_in_wire
      assign s1_valid = bus.in_valid;
      assign s1_op    = bus.in_op;
      assign s1_qh    = bus.in_qh;
      assign s1_tag   = bus.in_tag;
      assign s1_a     = bus.in_a;
      assign s1_b     = bus.in_b;
    end
  endgenerate

  generate
    if (LOGQ == LOGQ_DEF && LOGQH == LOGQH_DEF) begin : g_q_pkg
      assign q1 = q_expand(s1_qh);
    end else begin : g_q_generic
      assign q1 = {s1_qh, {(LOGQ-LOGQH-1){1'b0}}, 1'b1};
    end
  endgenerate

  generate
    if (FF_OP != 0) begin : g_op_reg
      // Sideband travelling alongside the registered candidates.
      always_ff @(posedge clk) begin
        if (rst) begin
          s2_valid <= 1'b0;
          s2_op    <= 1'b0;
          s2_tag   <= '0;
        end else if (en) begin
          s2_valid <= s1_valid;
          s2_op    <= s1_op;
          s2_tag   <= s1_tag;
        end
      end
    end else begin : g_op_wire
      assign s2_valid = s1_valid;
      assign s2_op    = s1_op;
      assign s2_tag   = s1_tag;
    end
  endgenerate

  generate
    if (FF_OUT != 0) begin : g_out_reg
      // Sideband travelling alongside the registered lane results.
      always_ff @(posedge clk) begin
        if (rst) begin
          s3_valid <= 1'b0;
          s3_tag   <= '0;
        end else if (en) begin
          s3_valid <= s2_valid;
          s3_tag   <= s2_tag;
        end
      end
    end else begin : g_out_wire
      assign s3_valid = s2_valid;
      assign s3_tag   = s2_tag;
    end
  endgenerate

  generate
    for (genvar l = 0; l < NLANE; l++) begin : g_lane
      modaddsub_lane #(
        .LOGQ   (LOGQ),
        .FF_OP  (FF_OP),
        .FF_OUT (FF_OUT)
      ) u_lane (
        .clk     (clk),
        .rst     (rst),
        .en      (en),
        .op_cand (s1_op),
        .op_sel  (s2_op),
        .q       (q1),
        .a       (s1_a[l*LOGQ +: LOGQ]),
        .b       (s1_b[l*LOGQ +: LOGQ]),
        .c       (lane_c[l*LOGQ +: LOGQ])
      );
    end
  endgenerate

  assign bus.out_valid = s3_valid;
  assign bus.out_tag   = s3_tag;
  assign bus.out_c     = lane_c;

endmodule
